icap_multiboot_ctrl: RTL and testbench

//  Runtime-addressed MultiBoot sequencer for the Spartan-3A ICAP_SPARTAN3A port.

---
 rtl/icap_multiboot_ctrl_pkg.sv | 64 ++++++
 rtl/icap_clk_strobe.sv | 45 ++++
 rtl/icap_multiboot_ctrl.sv | 109 ++++++++++
 tb/tb_icap_multiboot_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/icap_multiboot_ctrl_pkg.sv
// Shared constants, state encoding and byte table for the
// ICAP MultiBoot sequencer.
package icap_multiboot_ctrl_pkg;

  localparam int         SEQ_LEN  = 20;
  localparam logic [4:0] SEQ_LAST = 5'(SEQ_LEN - 1);
  localparam logic [4:0] CE_FIRST = 5'd2;
  localparam logic [4:0] CE_LAST  = 5'd17;

  localparam logic [7:0] SYNC_HI   = 8'hAA;
  localparam logic [7:0] SYNC_LO   = 8'h99;
  localparam logic [7:0] GEN1_HI   = 8'h32;
  localparam logic [7:0] GEN1_LO   = 8'h61;
  localparam logic [7:0] GEN2_HI   = 8'h32;
  localparam logic [7:0] GEN2_LO   = 8'h81;
  localparam logic [7:0] CMD_HI    = 8'h30;
  localparam logic [7:0] CMD_LO    = 8'hA1;
  localparam logic [7:0] REBOOT_HI = 8'h00;
  localparam logic [7:0] REBOOT_LO = 8'h0E;
  localparam logic [7:0] NOOP_HI   = 8'h20;
  localparam logic [7:0] NOOP_LO   = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  function automatic logic [7:0] seq_byte(
    input logic [4:0]  idx,
    input logic [23:0] addr,
    input logic [7:0]  rd_op
  );
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      5'd2:    b = SYNC_HI;
      5'd3:    b = SYNC_LO;
      5'd4:    b = GEN1_HI;
      5'd5:    b = GEN1_LO;
      5'd6:    b = addr[15:8];
      5'd7:    b = addr[7:0];
      5'd8:    b = GEN2_HI;
      5'd9:    b = GEN2_LO;
      5'd10:   b = rd_op;
      5'd11:   b = addr[23:16];
      5'd12:   b = CMD_HI;
      5'd13:   b = CMD_LO;
      5'd14:   b = REBOOT_HI;
      5'd15:   b = REBOOT_LO;
      5'd16:   b = NOOP_HI;
      5'd17:   b = NOOP_LO;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic ce_active(
    input logic [4:0] idx
  );
    return (idx >= CE_FIRST) && (idx <= CE_LAST);
  endfunction

endpackage

// File: rtl/icap_clk_strobe.sv
// Phase counter producing the registered ICAP clock and
// the end-of-byte-window advance strobe.
module icap_clk_strobe #(
  parameter int CLK_DIV = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  output logic o_icap_clk,
  output logic o_byte_adv
);

  localparam logic [3:0] PH_LAST = 4'(CLK_DIV - 1);
  localparam logic [3:0] PH_HIGH = 4'(CLK_DIV / 2);

  logic [3:0] r_phase;
  logic [3:0] w_phase_next;
  logic       r_icap_clk;

  always_comb begin
    w_phase_next = r_phase + 4'd1;
    if (r_phase == PH_LAST) w_phase_next = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_run) begin
      r_phase <= '0;
    end else begin
      r_phase <= w_phase_next;
    end
  end

  // High during the cycle whose phase equals PH_HIGH
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_icap_clk <= 1'b0;
    end else begin
      r_icap_clk <= i_run && (w_phase_next == PH_HIGH);
    end
  end

  assign o_icap_clk = r_icap_clk;
  assign o_byte_adv = i_run && (r_phase == PH_LAST);

endmodule

// File: rtl/icap_multiboot_ctrl.sv
// Runtime-addressed MultiBoot sequencer: streams the 20-byte
// reboot packet into ICAP_SPARTAN3A for a requested address.
module icap_multiboot_ctrl
  import icap_multiboot_ctrl_pkg::*;
#(
  parameter int         CLK_DIV   = 3,
  parameter logic [7:0] RD_OPCODE = 8'h00,
  parameter bit         REQ_LOCK  = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic        i_req,
  input  logic [23:0] i_addr,
  output logic        o_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic [7:0]  o_icap_i,
  output logic        o_icap_ce_n,
  output logic        o_icap_wr_n,
  output logic        o_icap_clk
);

  if (CLK_DIV < 3 || CLK_DIV > 15) begin : g_bad_div
    $error("CLK_DIV must be within 3..15");
  end

  state_t      r_state;
  state_t      w_state_next;
  logic [4:0]  r_idx;
  logic [4:0]  w_idx_inc;
  logic [23:0] r_addr;
  logic [7:0]  r_data;
  logic        r_ce_n;
  logic        w_ready;
  logic        w_accept;
  logic        w_run;
  logic        w_byte_adv;

  assign w_run     = (r_state == ST_SEND);
  assign w_idx_inc = r_idx + 5'd1;
  assign w_ready   = (r_state == ST_IDLE) && !i_rst &&
                     (i_enable || !REQ_LOCK);
  assign w_accept  = i_req && w_ready;

  icap_clk_strobe #(
    .CLK_DIV (CLK_DIV)
  ) u_strobe (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_run      (w_run),
    .o_icap_clk (o_icap_clk),
    .o_byte_adv (w_byte_adv)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept) w_state_next = ST_SEND;
      ST_SEND: begin
        if (w_byte_adv && r_idx == SEQ_LAST)
          w_state_next = ST_FIN;
      end
      ST_FIN:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Data and CE load one edge ahead so each window is stable
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx  <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_ce_n <= 1'b1;
    end else if (w_accept) begin
      r_idx  <= '0;
      r_addr <= i_addr;
      r_data <= seq_byte(5'd0, i_addr, RD_OPCODE);
      r_ce_n <= !ce_active(5'd0);
    end else if (w_byte_adv) begin
      if (r_idx == SEQ_LAST) begin
        r_data <= '0;
        r_ce_n <= 1'b1;
      end else begin
        r_idx  <= w_idx_inc;
        r_data <= seq_byte(w_idx_inc, r_addr, RD_OPCODE);
        r_ce_n <= !ce_active(w_idx_inc);
      end
    end
  end

  always_comb begin
    o_icap_i = '0;
    for (int i = 0; i < 8; i++) o_icap_i[i] = r_data[7-i];
  end

  assign o_icap_ce_n = r_ce_n;
  assign o_icap_wr_n = r_ce_n;
  assign o_ready     = w_ready;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = (r_state == ST_FIN);

endmodule

// File: tb/tb_icap_multiboot_ctrl.sv
// Directed bench for icap_multiboot_ctrl: a CLK_DIV=3 instance
// and a CLK_DIV=7 / RD_OPCODE=0B instance.
module tb_icap_multiboot_ctrl;

  typedef logic [19:0][7:0] tbl_t;

  localparam logic [159:0] S1 =
    160'h0000AA99326100003281000230A1000E20000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, en_a, req_a;
  logic [23:0] addr_a;
  logic        a_ready, a_busy, a_done, a_ce_n, a_wr_n, a_iclk;
  logic [7:0]  a_icap_i;

  logic        rst_b, en_b, req_b;
  logic [23:0] addr_b;
  logic        b_ready, b_busy, b_done, b_ce_n, b_wr_n, b_iclk;
  logic [7:0]  b_icap_i;

  icap_multiboot_ctrl #(
    .CLK_DIV(3), .RD_OPCODE(8'h00), .REQ_LOCK(1'b1)
  ) u_a (
    .i_clk(clk), .i_rst(rst_a), .i_enable(en_a),
    .i_req(req_a), .i_addr(addr_a),
    .o_ready(a_ready), .o_busy(a_busy), .o_done(a_done),
    .o_icap_i(a_icap_i), .o_icap_ce_n(a_ce_n),
    .o_icap_wr_n(a_wr_n), .o_icap_clk(a_iclk)
  );

  icap_multiboot_ctrl #(
    .CLK_DIV(7), .RD_OPCODE(8'h0B), .REQ_LOCK(1'b1)
  ) u_b (
    .i_clk(clk), .i_rst(rst_b), .i_enable(en_b),
    .i_req(req_b), .i_addr(addr_b),
    .o_ready(b_ready), .o_busy(b_busy), .o_done(b_done),
    .o_icap_i(b_icap_i), .o_icap_ce_n(b_ce_n),
    .o_icap_wr_n(b_wr_n), .o_icap_clk(b_iclk)
  );

  logic       sel;
  logic       m_ready, m_busy, m_done, m_ce_n, m_wr_n, m_iclk;
  logic [7:0] m_icap_i;

  assign m_ready  = sel ? b_ready  : a_ready;
  assign m_busy   = sel ? b_busy   : a_busy;
  assign m_done   = sel ? b_done   : a_done;
  assign m_ce_n   = sel ? b_ce_n   : a_ce_n;
  assign m_wr_n   = sel ? b_wr_n   : a_wr_n;
  assign m_iclk   = sel ? b_iclk   : a_iclk;
  assign m_icap_i = sel ? b_icap_i : a_icap_i;

  int checks = 0;
  int errors = 0;

  function automatic tbl_t mk_tbl(input logic [23:0] a,
                                  input logic [7:0] rd);
    tbl_t t;
    t = '0;
    t[2] = 8'hAA; t[3] = 8'h99;
    t[4] = 8'h32; t[5] = 8'h61;
    t[6] = a[15:8]; t[7] = a[7:0];
    t[8] = 8'h32; t[9] = 8'h81;
    t[10] = rd; t[11] = a[23:16];
    t[12] = 8'h30; t[13] = 8'hA1;
    t[14] = 8'h00; t[15] = 8'h0E;
    t[16] = 8'h20; t[17] = 8'h00;
    return t;
  endfunction

  function automatic tbl_t from_str(input logic [159:0] v);
    tbl_t t;
    for (int i = 0; i < 20; i++) t[i] = v[159-8*i -: 8];
    return t;
  endfunction

  function automatic logic [7:0] unrev(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic v);
    if (sel) req_b = v; else req_a = v;
  endtask
  task automatic set_en(input logic v);
    if (sel) en_b = v; else en_a = v;
  endtask
  task automatic set_rst(input logic v);
    if (sel) rst_b = v; else rst_a = v;
  endtask
  task automatic set_addr(input logic [23:0] v);
    if (sel) addr_b = v; else addr_a = v;
  endtask

  task automatic accept_req(input logic [23:0] a, input bit hold);
    @(negedge clk);
    set_addr(a);
    set_req(1'b1);
    chk("ready_pre_accept", 32'(m_ready), 32'd1);
    @(posedge clk);
    #1;
    if (!hold) set_req(1'b0);
  endtask

  task automatic check_seq(input int div, input tbl_t exp,
                           input bit disturb,
                           input logic [23:0] a);
    int pulses;
    int ce_pulses;
    int idx;
    int ph;
    logic ce_exp;
    pulses = 0;
    ce_pulses = 0;
    for (int k = 1; k <= 20 * div; k++) begin
      @(negedge clk);
      idx = (k - 1) / div;
      ph  = (k - 1) % div;
      ce_exp = !(idx >= 2 && idx <= 17);
      chk("icap_clk", 32'(m_iclk), 32'(ph == div / 2));
      chk("icap_byte", 32'(unrev(m_icap_i)), 32'(exp[idx]));
      chk("ce_n", 32'(m_ce_n), 32'(ce_exp));
      chk("wr_n", 32'(m_wr_n), 32'(ce_exp));
      chk("busy_send", 32'(m_busy), 32'd1);
      chk("ready_send", 32'(m_ready), 32'd0);
      chk("done_send", 32'(m_done), 32'd0);
      if (m_iclk === 1'b1) begin
        pulses++;
        if (m_ce_n === 1'b0) ce_pulses++;
      end
      if (disturb && k == 5) begin
        set_req(1'b1);
        set_en(1'b0);
        set_addr(~a);
      end
      if (disturb && k == 9) begin
        set_req(1'b0);
        set_en(1'b1);
      end
    end
    @(negedge clk);
    chk("done_pulse", 32'(m_done), 32'd1);
    chk("busy_fin", 32'(m_busy), 32'd1);
    chk("icap_clk_count", pulses, 20);
    chk("ce_low_clk_count", ce_pulses, 16);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, 32'(m_ready), 32'd1);
    chk({tag, "_busy"}, 32'(m_busy), 32'd0);
    chk({tag, "_done"}, 32'(m_done), 32'd0);
    chk({tag, "_ce_n"}, 32'(m_ce_n), 32'd1);
  endtask

  initial begin
    sel = 1'b0;
    rst_a = 1'b1; en_a = 1'b1; req_a = 1'b0; addr_a = '0;
    rst_b = 1'b1; en_b = 1'b1; req_b = 1'b0; addr_b = '0;
    repeat (3) @(negedge clk);

    chk("rst_ready", 32'(a_ready), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_icap_i", 32'(a_icap_i), 32'd0);
    chk("rst_ce_n", 32'(a_ce_n), 32'd1);
    chk("rst_wr_n", 32'(a_wr_n), 32'd1);
    chk("rst_icap_clk", 32'(a_iclk), 32'd0);
    chk("rst_ready_b", 32'(b_ready), 32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    chk("post_rst_ready_a", 32'(a_ready), 32'd1);
    chk("post_rst_ready_b", 32'(b_ready), 32'd1);

    // Sequence at 020000 with req/enable/addr disturbed mid-run
    accept_req(24'h020000, 1'b0);
    check_seq(3, from_str(S1), 1'b1, 24'h020000);
    @(negedge clk);
    chk_idle("after_seq1");

    // enable low in IDLE blocks the request
    set_en(1'b0);
    set_req(1'b1);
    repeat (4) begin
      @(negedge clk);
      chk("en0_ready", 32'(m_ready), 32'd0);
      chk("en0_busy", 32'(m_busy), 32'd0);
      chk("en0_ce_n", 32'(m_ce_n), 32'd1);
      chk("en0_icap_clk", 32'(m_iclk), 32'd0);
    end
    set_req(1'b0);
    set_en(1'b1);
    @(negedge clk);
    chk("en1_ready", 32'(m_ready), 32'd1);

    // reset during idx 5
    accept_req(24'h123456, 1'b0);
    repeat (16) @(negedge clk);
    chk("idx5_byte", 32'(unrev(m_icap_i)), 32'h61);
    set_rst(1'b1);
    @(negedge clk);
    chk("midrst_ce_n", 32'(m_ce_n), 32'd1);
    chk("midrst_wr_n", 32'(m_wr_n), 32'd1);
    chk("midrst_icap_clk", 32'(m_iclk), 32'd0);
    chk("midrst_busy", 32'(m_busy), 32'd0);
    chk("midrst_icap_i", 32'(m_icap_i), 32'd0);
    chk("midrst_ready", 32'(m_ready), 32'd0);
    set_rst(1'b0);
    @(negedge clk);
    chk("midrst_rel_ready", 32'(m_ready), 32'd1);
    chk("midrst_rel_clk", 32'(m_iclk), 32'd0);
    accept_req(24'h123456, 1'b0);
    check_seq(3, mk_tbl(24'h123456, 8'h00), 1'b0, 24'h123456);
    @(negedge clk);
    chk_idle("after_restart");

    // req tied high: back-to-back sequences
    accept_req(24'h111111, 1'b1);
    set_addr(24'h222222);
    check_seq(3, mk_tbl(24'h111111, 8'h00), 1'b0, 24'h111111);
    @(negedge clk);
    chk("b2b_ready", 32'(m_ready), 32'd1);
    chk("b2b_busy", 32'(m_busy), 32'd0);
    @(posedge clk);
    #1;
    set_addr(24'h333333);
    check_seq(3, mk_tbl(24'h222222, 8'h00), 1'b0, 24'h222222);
    set_req(1'b0);
    @(negedge clk);
    chk_idle("after_b2b");

    // CLK_DIV=7 instance, RD_OPCODE 0B
    sel = 1'b1;
    accept_req(24'hABCDEF, 1'b0);
    check_seq(7, mk_tbl(24'hABCDEF, 8'h0B), 1'b1, 24'hABCDEF);
    @(negedge clk);
    chk_idle("after_div7");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
